// File: rtl/lin_sched_pkg.sv
// Shared types and defaults for the LIN schedule controller: FSM state encoding,
// default tick counts and the schedule-slot wrap helper.
package lin_sched_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_SLOT_REQ,
        ST_SLOT_WAIT,
        ST_SLOT_GAP,
        ST_SLEEP_REQ,
        ST_SLEEP_WAIT,
        ST_SLEEP,
        ST_WAKEUP
    } state_t;

    localparam int unsigned DEF_INIT_TICKS  = 16;
    localparam int unsigned DEF_SLOT_TICKS  = 100;
    localparam int unsigned DEF_WAKE_TICKS  = 20;
    localparam int unsigned DEF_INACT_TICKS = 4000;
    localparam int unsigned DEF_CNT_W       = 16;

    // Next schedule slot; wraps to 0 after the last latched slot (n >= 1)
    function automatic logic [7:0] next_slot(input logic [7:0] idx, input logic [7:0] n);
        return (idx == n - 8'd1) ? 8'd0 : idx + 8'd1;
    endfunction

endpackage

// File: rtl/lin_schedule_ctrl_if.sv
// Register-file / frame-engine side signals of the LIN schedule controller.
// master drives commands and strobes; slave is the controller itself.
interface lin_schedule_ctrl_if;

    logic       bit_tick;
    logic       en_schedule;
    logic [7:0] nb_of_frames;
    logic       en_diagnostic;
    logic       sleep_cmd;
    logic       wakeup_cmd;
    logic       bus_activity;
    logic       frame_done;

    logic       frame_req;
    logic [7:0] frame_idx;
    logic       diag_frame;
    logic       send_sleep;
    logic       send_wakeup;
    logic       slot_timeout;
    logic       INIT_FINISH;
    logic       bus_inactive;
    logic       end_diagnostic;

    modport master (
        output bit_tick, en_schedule, nb_of_frames, en_diagnostic,
               sleep_cmd, wakeup_cmd, bus_activity, frame_done,
        input  frame_req, frame_idx, diag_frame, send_sleep, send_wakeup,
               slot_timeout, INIT_FINISH, bus_inactive, end_diagnostic
    );

    modport slave (
        input  bit_tick, en_schedule, nb_of_frames, en_diagnostic,
               sleep_cmd, wakeup_cmd, bus_activity, frame_done,
        output frame_req, frame_idx, diag_frame, send_sleep, send_wakeup,
               slot_timeout, INIT_FINISH, bus_inactive, end_diagnostic
    );

endinterface

// File: rtl/lin_tick_timer.sv
// bit_tick counter with synchronous clear. o_hit: count equals limit now;
// o_last: this edge's tick brings the count to limit.
module lin_tick_timer #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_hit,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == i_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && i_tick && !(SATURATE && w_at_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit  = w_at_limit;
    assign o_last = i_en && i_tick && (r_cnt == i_limit - 1'b1);

endmodule

// File: rtl/lin_schedule_ctrl.sv
// LIN schedule controller: turns register-file control bits into bit_tick-timed
// frame requests, sleep/wakeup strobes and INIT/inactivity/diagnostic status levels.
module lin_schedule_ctrl
    import lin_sched_pkg::*;
#(
    parameter int unsigned INIT_TICKS  = DEF_INIT_TICKS,
    parameter int unsigned SLOT_TICKS  = DEF_SLOT_TICKS,
    parameter int unsigned WAKE_TICKS  = DEF_WAKE_TICKS,
    parameter int unsigned INACT_TICKS = DEF_INACT_TICKS,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    lin_schedule_ctrl_if.slave bus
);

    state_t           r_state;
    logic [7:0]       r_idx;
    logic [7:0]       r_n_lat;
    logic             r_pass_diag;
    logic             r_frame_req;
    logic [7:0]       r_frame_idx;
    logic             r_diag_frame;
    logic             r_send_sleep;
    logic             r_send_wakeup;
    logic             r_slot_timeout;
    logic             r_init_finish;
    logic             r_end_diag;
    logic             r_bus_inactive;

    logic [CNT_W-1:0] w_tmr_limit;
    logic             w_tmr_en;
    logic             w_tmr_clr;
    logic             w_tmr_hit;
    logic             w_tmr_last;
    logic             w_slot_end;
    logic             w_boundary;
    logic [7:0]       w_idx_next;
    logic             w_wrap;
    logic             w_inact_clr;
    logic             w_inact_hit;
    logic             w_inact_last;

    // One timer serves INIT, slot and WAKEUP timing; only one is ever active
    always_comb begin
        w_tmr_limit = CNT_W'(SLOT_TICKS);
        if (r_state == ST_INIT) begin
            w_tmr_limit = CNT_W'(INIT_TICKS);
        end else if (r_state == ST_WAKEUP) begin
            w_tmr_limit = CNT_W'(WAKE_TICKS);
        end
    end

    assign w_slot_end = w_tmr_last || w_tmr_hit;
    assign w_boundary = ((r_state == ST_SLOT_WAIT) || (r_state == ST_SLOT_GAP)) && w_slot_end;
    assign w_tmr_en   = (r_state != ST_IDLE) && (r_state != ST_SLEEP);
    // Clearing on the boundary edge keeps the slot period anchored to frame_req
    assign w_tmr_clr  = !w_tmr_en || w_boundary;
    assign w_idx_next = next_slot(r_idx, r_n_lat);
    assign w_wrap     = (w_idx_next == 8'd0);

    lin_tick_timer #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_seq_tmr (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_tick  (bus.bit_tick),
        .i_limit (w_tmr_limit),
        .o_hit   (w_tmr_hit),
        .o_last  (w_tmr_last)
    );

    assign w_inact_clr = bus.bus_activity || (r_state == ST_INIT);

    lin_tick_timer #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_inact_tmr (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_inact_clr),
        .i_en    (1'b1),
        .i_tick  (bus.bit_tick),
        .i_limit (CNT_W'(INACT_TICKS)),
        .o_hit   (w_inact_hit),
        .o_last  (w_inact_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_inactive <= 1'b0;
        end else begin
            r_bus_inactive <= !w_inact_clr && (w_inact_hit || w_inact_last);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_INIT;
            r_idx          <= 8'd0;
            r_n_lat        <= 8'd0;
            r_pass_diag    <= 1'b0;
            r_frame_req    <= 1'b0;
            r_frame_idx    <= 8'd0;
            r_diag_frame   <= 1'b0;
            r_send_sleep   <= 1'b0;
            r_send_wakeup  <= 1'b0;
            r_slot_timeout <= 1'b0;
            r_init_finish  <= 1'b0;
            r_end_diag     <= 1'b0;
        end else begin
            r_frame_req    <= 1'b0;
            r_send_sleep   <= 1'b0;
            r_send_wakeup  <= 1'b0;
            r_slot_timeout <= 1'b0;
            if (!bus.en_diagnostic) begin
                r_end_diag <= 1'b0;
            end

            case (r_state)
                ST_INIT: begin
                    if (w_tmr_last) begin
                        r_init_finish <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.sleep_cmd) begin
                        r_send_sleep <= 1'b1;
                        r_state      <= ST_SLEEP_REQ;
                    end else if (bus.en_schedule && (bus.nb_of_frames != 8'd0)) begin
                        r_idx        <= 8'd0;
                        r_n_lat      <= bus.nb_of_frames;
                        r_frame_req  <= 1'b1;
                        r_frame_idx  <= 8'd0;
                        r_diag_frame <= bus.en_diagnostic;
                        r_pass_diag  <= bus.en_diagnostic;
                        r_state      <= ST_SLOT_REQ;
                    end
                end
                ST_SLOT_REQ: begin
                    r_state <= ST_SLOT_WAIT;
                end
                ST_SLOT_WAIT, ST_SLOT_GAP: begin
                    if (w_boundary) begin
                        if ((r_state == ST_SLOT_WAIT) && !bus.frame_done) begin
                            r_slot_timeout <= 1'b1;
                        end
                        r_idx <= w_idx_next;
                        if (w_wrap) begin
                            r_n_lat <= bus.nb_of_frames;
                            if (r_pass_diag && bus.en_diagnostic) begin
                                r_end_diag <= 1'b1;
                            end
                        end
                        if (bus.sleep_cmd) begin
                            r_send_sleep <= 1'b1;
                            r_state      <= ST_SLEEP_REQ;
                        end else if (!bus.en_schedule || (w_wrap && (bus.nb_of_frames == 8'd0))) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_req  <= 1'b1;
                            r_frame_idx  <= w_idx_next;
                            r_diag_frame <= bus.en_diagnostic;
                            r_pass_diag  <= w_wrap ? bus.en_diagnostic
                                                   : (r_pass_diag && bus.en_diagnostic);
                            r_state      <= ST_SLOT_REQ;
                        end
                    end else if ((r_state == ST_SLOT_WAIT) && bus.frame_done) begin
                        r_state <= ST_SLOT_GAP;
                    end
                end
                ST_SLEEP_REQ: begin
                    r_state <= ST_SLEEP_WAIT;
                end
                ST_SLEEP_WAIT: begin
                    if (bus.frame_done || w_slot_end) begin
                        r_state <= ST_SLEEP;
                    end
                end
                ST_SLEEP: begin
                    // Local wakeup request takes precedence over a coincident remote one
                    if (bus.wakeup_cmd) begin
                        r_send_wakeup <= 1'b1;
                        r_state       <= ST_WAKEUP;
                    end else if (bus.bus_activity) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAKEUP: begin
                    if (w_tmr_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.frame_req      = r_frame_req;
    assign bus.frame_idx      = r_frame_idx;
    assign bus.diag_frame     = r_diag_frame;
    assign bus.send_sleep     = r_send_sleep;
    assign bus.send_wakeup    = r_send_wakeup;
    assign bus.slot_timeout   = r_slot_timeout;
    assign bus.INIT_FINISH    = r_init_finish;
    assign bus.bus_inactive   = r_bus_inactive;
    assign bus.end_diagnostic = r_end_diag;

endmodule
